// File: rtl/bp_commit_tracker.sv
// ---------------------------------------------------------------------------
// bp_commit_tracker
//
// In-order branch tracker feeding the 2-bit branch predictor update port.
// The fetcher pushes every predicted branch (predictor index + predicted
// direction) into a circular buffer. The branch ALU resolves slots out of
// order by slot index. Branches retire strictly in program order, at most one
// per cycle, and each retirement produces a one-cycle predictor update pulse.
// A mispredicted retirement empties the whole tracker.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; when low all state and outputs hold
//   in_flush          external pipeline flush (clears entries, keeps stats)
//   in_fetch_*        push request: valid, predictor tag, predicted taken
//   out_fetch_idx     slot the next push will occupy (current tail)
//   out_full          no free slot
//   in_res_*          resolution: valid strobe, slot index, actual taken
//   out_bp_res        predictor update strobe (registered)
//   out_bp_tag        predictor index to update
//   out_bp_jump       actual branch outcome
//   out_mispredict    retired branch was mispredicted
//   out_stat_total    retired-branch count (wraps)
//   out_stat_miss     mispredicted-branch count (wraps)
// ---------------------------------------------------------------------------
module bp_commit_tracker #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_flush,
  input  logic             in_fetch_valid,
  input  logic [TAG_W-1:0] in_fetch_tag,
  input  logic             in_fetch_pred,
  output logic [IDX_W-1:0] out_fetch_idx,
  output logic             out_full,
  input  logic             in_res_valid,
  input  logic [IDX_W-1:0] in_res_idx,
  input  logic             in_res_jump,
  output logic             out_bp_res,
  output logic [TAG_W-1:0] out_bp_tag,
  output logic             out_bp_jump,
  output logic             out_mispredict,
  output logic [31:0]      out_stat_total,
  output logic [31:0]      out_stat_miss
);

  localparam logic [IDX_W:0]   LP_FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LP_PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   LP_CNT_ONE  = (IDX_W+1)'(1);

  // Per-slot control bits (reset) and payload (not reset; qualified by valid)
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [DEPTH-1:0] r_pred;
  logic [DEPTH-1:0] r_actual;
  logic [TAG_W-1:0] r_tag [DEPTH];

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic             r_bp_res;
  logic [TAG_W-1:0] r_bp_tag;
  logic             r_bp_jump;
  logic             r_mispredict;
  logic [31:0]      r_stat_total;
  logic [31:0]      r_stat_miss;

  logic w_active;
  logic w_full;
  logic w_retire;
  logic w_miss;
  logic w_push;
  logic w_resolve;

  // Flush overrides every rdy-gated action in the same cycle.
  assign w_active  = rdy & ~in_flush;
  assign w_full    = (r_count == LP_FULL_CNT);
  // Retirement looks only at registered state, so a resolve of the head slot
  // in this cycle retires one cycle later.
  assign w_retire  = w_active & r_valid[r_head] & r_resolved[r_head];
  assign w_miss    = w_retire & (r_pred[r_head] ^ r_actual[r_head]);
  // Full is sampled before the edge: a retire never makes room for a push
  // in the same cycle.
  assign w_push    = w_active & in_fetch_valid & ~w_full;
  assign w_resolve = w_active & in_res_valid & r_valid[in_res_idx];

  assign out_fetch_idx  = r_tail;
  assign out_full       = w_full;
  assign out_bp_res     = r_bp_res;
  assign out_bp_tag     = r_bp_tag;
  assign out_bp_jump    = r_bp_jump;
  assign out_mispredict = r_mispredict;
  assign out_stat_total = r_stat_total;
  assign out_stat_miss  = r_stat_miss;

  // Control state: slot flags, pointers, count, update strobes and stats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_resolved   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_bp_res     <= 1'b0;
      r_bp_tag     <= '0;
      r_bp_jump    <= 1'b0;
      r_mispredict <= 1'b0;
      r_stat_total <= 32'd0;
      r_stat_miss  <= 32'd0;
    end else if (in_flush) begin
      // Entries are dropped; statistics survive a pipeline flush.
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_bp_res     <= 1'b0;
      r_bp_tag     <= '0;
      r_bp_jump    <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (rdy) begin
      r_bp_res     <= w_retire;
      r_bp_tag     <= w_retire ? r_tag[r_head] : '0;
      r_bp_jump    <= w_retire & r_actual[r_head];
      r_mispredict <= w_miss;
      if (w_retire) begin
        r_stat_total <= r_stat_total + 32'd1;
      end
      if (w_miss) begin
        r_stat_miss <= r_stat_miss + 32'd1;
      end

      if (w_miss) begin
        // Everything younger than a mispredicted branch is wrong-path work.
        r_valid <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_resolve) begin
          r_resolved[in_res_idx] <= 1'b1;
        end
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + LP_PTR_ONE;
        end
        // Tail slot is never valid when a push is accepted, so it cannot
        // collide with the resolve or retire writes above.
        if (w_push) begin
          r_valid[r_tail]    <= 1'b1;
          r_resolved[r_tail] <= 1'b0;
          r_tail             <= r_tail + LP_PTR_ONE;
        end
        if (w_push && !w_retire) begin
          r_count <= r_count + LP_CNT_ONE;
        end else if (!w_push && w_retire) begin
          r_count <= r_count - LP_CNT_ONE;
        end
      end
    end
  end

  // Slot payload: written on accepted pushes and resolves only.
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_miss) begin
      r_tag[r_tail]  <= in_fetch_tag;
      r_pred[r_tail] <= in_fetch_pred;
    end
    if (!rst && w_resolve && !w_miss) begin
      r_actual[in_res_idx] <= in_res_jump;
    end
  end

endmodule

// File: tb/tb_bp_commit_tracker.sv
module tb_bp_commit_tracker;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             in_flush;
  logic             in_fetch_valid;
  logic [TAG_W-1:0] in_fetch_tag;
  logic             in_fetch_pred;
  logic [IDX_W-1:0] out_fetch_idx;
  logic             out_full;
  logic             in_res_valid;
  logic [IDX_W-1:0] in_res_idx;
  logic             in_res_jump;
  logic             out_bp_res;
  logic [TAG_W-1:0] out_bp_tag;
  logic             out_bp_jump;
  logic             out_mispredict;
  logic [31:0]      out_stat_total;
  logic [31:0]      out_stat_miss;

  always #5 clk = ~clk;

  bp_commit_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
    .in_fetch_valid(in_fetch_valid), .in_fetch_tag(in_fetch_tag),
    .in_fetch_pred(in_fetch_pred), .out_fetch_idx(out_fetch_idx),
    .out_full(out_full), .in_res_valid(in_res_valid), .in_res_idx(in_res_idx),
    .in_res_jump(in_res_jump), .out_bp_res(out_bp_res), .out_bp_tag(out_bp_tag),
    .out_bp_jump(out_bp_jump), .out_mispredict(out_mispredict),
    .out_stat_total(out_stat_total), .out_stat_miss(out_stat_miss)
  );

  // Reference model: program-ordered list of in-flight branches.
  typedef struct {
    int         idx;
    logic [7:0] tag;
    bit         pred;
    bit         res;
    bit         act;
  } ent_t;

  ent_t        m_q[$];
  int          m_tail;
  bit          e_res, e_jump, e_mis;
  logic [7:0]  e_tag;
  int unsigned e_total, e_miss;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ret, miss, full;
    if (rst) begin
      m_q.delete(); m_tail = 0;
      e_res = 0; e_tag = 8'h00; e_jump = 0; e_mis = 0;
      e_total = 0; e_miss = 0;
    end else if (in_flush) begin
      m_q.delete(); m_tail = 0;
      e_res = 0; e_tag = 8'h00; e_jump = 0; e_mis = 0;
    end else if (rdy) begin
      ret  = (m_q.size() > 0) && m_q[0].res;
      miss = ret && (m_q[0].pred != m_q[0].act);
      full = (m_q.size() == DEPTH);
      if (ret) begin
        e_res = 1; e_tag = m_q[0].tag; e_jump = m_q[0].act; e_mis = miss;
        e_total++;
        if (miss) e_miss++;
      end else begin
        e_res = 0; e_tag = 8'h00; e_jump = 0; e_mis = 0;
      end
      if (miss) begin
        m_q.delete(); m_tail = 0;
      end else begin
        if (in_res_valid) begin
          foreach (m_q[i]) begin
            if (m_q[i].idx == int'(in_res_idx)) begin
              m_q[i].res = 1;
              m_q[i].act = in_res_jump;
            end
          end
        end
        if (ret) void'(m_q.pop_front());
        if (in_fetch_valid && !full) begin
          m_q.push_back('{idx: m_tail, tag: in_fetch_tag, pred: in_fetch_pred, res: 1'b0, act: 1'b0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("bp_res",     32'(out_bp_res),     32'(e_res));
    check_eq("bp_tag",     32'(out_bp_tag),     32'(e_tag));
    check_eq("bp_jump",    32'(out_bp_jump),    32'(e_jump));
    check_eq("mispredict", 32'(out_mispredict), 32'(e_mis));
    check_eq("full",       32'(out_full),       32'(m_q.size() == DEPTH));
    check_eq("fetch_idx",  32'(out_fetch_idx),  32'(m_tail));
    check_eq("stat_total", out_stat_total,      e_total);
    check_eq("stat_miss",  out_stat_miss,       e_miss);
  endtask

  // Inputs are already applied; advance one clock and compare.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit fv, input logic [7:0] ft, input bit fp,
                     input bit rv, input logic [3:0] ri, input bit rj);
    rst = 0; in_flush = 0; rdy = 1;
    in_fetch_valid = fv; in_fetch_tag = ft; in_fetch_pred = fp;
    in_res_valid = rv; in_res_idx = ri; in_res_jump = rj;
    step();
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1; rdy = 1; in_flush = 0;
    in_fetch_valid = 0; in_fetch_tag = 8'h00; in_fetch_pred = 0;
    in_res_valid = 0; in_res_idx = 4'd0; in_res_jump = 0;
    m_tail = 0;
    step(); step();
    check_eq("reset_fetch_idx", 32'(out_fetch_idx), 32'd0);
    check_eq("reset_bp_res",    32'(out_bp_res),    32'd0);
    check_eq("reset_total",     out_stat_total,     32'd0);

    // In-order retirement of two correctly predicted branches
    idle();
    cyc(1, 8'h12, 1, 0, 4'd0, 0);
    cyc(1, 8'h34, 0, 0, 4'd0, 0);
    cyc(0, 8'h00, 0, 1, 4'd1, 0);
    cyc(0, 8'h00, 0, 1, 4'd0, 1);
    idle();
    check_eq("t1_res0", 32'(out_bp_res), 32'd1);
    check_eq("t1_tag0", 32'(out_bp_tag), 32'h12);
    idle();
    check_eq("t1_res1", 32'(out_bp_res), 32'd1);
    check_eq("t1_tag1", 32'(out_bp_tag), 32'h34);
    check_eq("t1_mis1", 32'(out_mispredict), 32'd0);
    idle();
    check_eq("t1_total", out_stat_total, 32'd2);
    check_eq("t1_miss",  out_stat_miss,  32'd0);

    // Mispredict empties the tracker; the younger 0x66 never retires
    cyc(1, 8'h55, 1, 0, 4'd0, 0);
    cyc(1, 8'h66, 0, 1, 4'd2, 0);
    idle();
    check_eq("t2_res",  32'(out_bp_res),     32'd1);
    check_eq("t2_tag",  32'(out_bp_tag),     32'h55);
    check_eq("t2_jump", 32'(out_bp_jump),    32'd0);
    check_eq("t2_mis",  32'(out_mispredict), 32'd1);
    check_eq("t2_idx",  32'(out_fetch_idx),  32'd0);
    check_eq("t2_miss", out_stat_miss,       32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 0, 1, 4'd3, 1);
      check_eq("t2_quiet", 32'(out_bp_res), 32'd0);
    end

    // Fill, overflow push, retire one, wrap to slot 0
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i + 8'h80), 0, 0, 4'd0, 0);
    check_eq("t3_full", 32'(out_full), 32'd1);
    check_eq("t3_idx",  32'(out_fetch_idx), 32'd0);
    cyc(1, 8'hAA, 1, 0, 4'd0, 0);
    check_eq("t3_drop_full", 32'(out_full), 32'd1);
    cyc(0, 8'h00, 0, 1, 4'd0, 0);
    idle();
    check_eq("t3_notfull", 32'(out_full), 32'd0);
    cyc(1, 8'hBB, 1, 0, 4'd0, 0);
    check_eq("t3_wrap_idx", 32'(out_fetch_idx), 32'd1);
    check_eq("t3_refull",   32'(out_full),      32'd1);

    // Resolve of a never-pushed slot
    do_reset();
    cyc(0, 8'h00, 0, 1, 4'd7, 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("t4_none", 32'(out_bp_res), 32'd0);
    end

    // Flush with resolved entries, then rdy low holds state
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0, 4'd0, 0);
    cyc(0, 8'h00, 0, 1, 4'd0, 0);
    cyc(0, 8'h00, 0, 1, 4'd2, 0);
    cyc(0, 8'h00, 0, 1, 4'd3, 0);
    cyc(0, 8'h00, 0, 1, 4'd4, 0);
    check_eq("t5_total_pre", out_stat_total, 32'd1);
    in_flush = 1;
    step();
    in_flush = 0;
    check_eq("t5_idx", 32'(out_fetch_idx), 32'd0);
    cyc(1, 8'h77, 1, 0, 4'd0, 0);
    cyc(0, 8'h00, 0, 1, 4'd0, 1);
    rdy = 0;
    in_fetch_valid = 1; in_fetch_tag = 8'h99; in_res_valid = 1; in_res_idx = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t5_hold_idx", 32'(out_fetch_idx), 32'd1);
    end
    idle();
    check_eq("t5_post_tag",   32'(out_bp_tag),  32'h77);
    check_eq("t5_total_post", out_stat_total,   32'd2);

    // Reset mid-stream with head=5, tail=9
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h20 + i), 1, 0, 4'd0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0, 1, 4'(i), 1);
    idle(); idle();
    check_eq("t6_tail", 32'(out_fetch_idx), 32'd9);
    check_eq("t6_total", out_stat_total, 32'd5);
    rst = 1;
    in_res_valid = 1; in_res_idx = 4'd5;
    step();
    rst = 0;
    check_eq("t6_idx",   32'(out_fetch_idx), 32'd0);
    check_eq("t6_res",   32'(out_bp_res),    32'd0);
    check_eq("t6_tot0",  out_stat_total,     32'd0);
    check_eq("t6_miss0", out_stat_miss,      32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int k;
      rst      = ($urandom_range(0, 299) == 0);
      in_flush = ($urandom_range(0, 59) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      in_fetch_valid = ($urandom_range(0, 2) != 0);
      in_fetch_tag   = 8'($urandom);
      in_fetch_pred  = 1'($urandom);
      in_res_valid   = ($urandom_range(0, 1) == 1);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, m_q.size() - 1);
        in_res_idx  = 4'(m_q[k].idx);
        in_res_jump = ($urandom_range(0, 7) == 0) ? ~m_q[k].pred : m_q[k].pred;
      end else begin
        in_res_idx  = 4'($urandom);
        in_res_jump = 1'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_commit_tracker.md
Name: bp_commit_tracker

Overview:
- In-order branch tracker; the writer side of the predictor update interface (bp_res / tag / jump_res).
- Fetcher pushes each predicted branch (index tag, predicted direction) at fetch; the execute stage resolves entries out of order by slot index.
- Entries retire in program order; each retirement drives a one-cycle predictor update pulse and flags mispredictions.
- Sits between the fetcher, branch ALU and the 256-entry 2-bit predictor table.

Parameters:
- DEPTH, 16, number of tracked branches (power of two).
- IDX_W, 4, log2(DEPTH).
- TAG_W, 8, predictor index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- in_flush  in  1  external pipeline flush
- in_fetch_valid  in  1  push request
- in_fetch_tag  in  TAG_W  predictor index of branch
- in_fetch_pred  in  1  predicted taken
- out_fetch_idx  out  IDX_W  slot the next push will occupy (current tail)
- out_full  out  1  no free slot
- in_res_valid  in  1  resolution strobe
- in_res_idx  in  IDX_W  slot being resolved
- in_res_jump  in  1  actual taken
- out_bp_res  out  1  predictor update strobe
- out_bp_tag  out  TAG_W  index to update
- out_bp_jump  out  1  actual outcome
- out_mispredict  out  1  retired branch was mispredicted
- out_stat_total  out  32  retired-branch count
- out_stat_miss  out  32  mispredicted-branch count

Behaviour:
- Storage: per slot valid, resolved, tag, pred, actual. head/tail pointers IDX_W bits, count IDX_W+1 bits; pointers wrap modulo DEPTH.
- out_full = (count == DEPTH), combinational. out_fetch_idx = tail, combinational.
- Reset: all valid/resolved cleared, head = tail = count = 0, out_bp_res = 0, out_bp_tag = 0, out_bp_jump = 0, out_mispredict = 0, both stat counters = 0.
- Push: if in_fetch_valid && !out_full → write slot[tail] (valid = 1, resolved = 0), tail++. A push while full is dropped; no state change.
- Resolve: if in_res_valid && slot[in_res_idx].valid → set resolved, store actual. A resolve to an invalid slot is ignored. Re-resolving an already-resolved slot overwrites actual.
- Retire, at most one per cycle: if slot[head].valid && slot[head].resolved → clear valid, head++. Next cycle: out_bp_res = 1, out_bp_tag = tag, out_bp_jump = actual, out_mispredict = (pred != actual). Otherwise these strobes are 0 next cycle. Latency is 1 cycle from the retire-eligible state to the strobe.
- A same-cycle resolve of the head slot does not retire in that cycle; it retires the following cycle.
- Mispredict flush: a retirement with pred != actual also clears all valid bits and sets head = tail = count = 0 in the same edge. Any push or resolve in that cycle is discarded.
- Stats: total++ on every retirement; miss++ on every mispredicted retirement. Both are 32-bit and wrap silently.
- in_flush: clears all entries and pointers as above, and suppresses retirement that cycle (no strobe next cycle). Stat counters are kept; pending output strobes from the previous cycle still appear.
- Simultaneous push + retire when full: retire frees a slot only after the edge, so the push is dropped (out_full was 1). Count is unchanged by push + retire with no flush.
- rst takes priority over in_flush, which takes priority over rdy-gated activity. rst mid-operation discards everything.

Test Plan:
- Push tags 0x12(pred 1), 0x34(pred 0); resolve idx1 jump 0, then idx0 jump 1 → retire 0x12 then 0x34 on consecutive cycles; out_bp_res pulses twice, out_mispredict = 0, total = 2, miss = 0.
- Push 0x55 pred 1, resolve jump 0 → out_bp_tag = 0x55, out_bp_jump = 0, out_mispredict = 1; queue emptied, out_fetch_idx = 0, younger pushed entries never retire, miss = 1.
- Push 16 entries → out_full = 1; 17th push ignored; retire one → out_full = 0; next push lands at idx 0 (wrap).
- Resolve a never-pushed idx 7 → no state change, no out_bp_res ever produced for it.
- in_flush with 3 resolved entries → no strobes afterward, count = 0, stat counters unchanged; rdy = 0 for 5 cycles holds all state.
- Assert rst mid-stream with head = 5, tail = 9 → all outputs and counters 0, out_fetch_idx = 0 next cycle.
